// File: rtl/mem_stage_pkg.sv
// Shared widths, one-hot mem opcode bit positions and drain FSM states for the MEM stage.
package mem_stage_pkg;

    localparam int XLEN         = 32;
    localparam int REG_AW       = 5;
    localparam int MEM_OP_WIDTH = 3;

    localparam int MEM_OP_BYTE = 0;
    localparam int MEM_OP_HALF = 1;
    localparam int MEM_OP_WORD = 2;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load extraction: shifts the addressed byte/half/word down and sign- or zero-extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [XLEN-1:0]         data_i,
    input  logic [1:0]              offset_i,
    input  logic [MEM_OP_WIDTH-1:0] opcode_i,
    input  logic                    unsign_i,
    output logic [XLEN-1:0]         result_o
);

    logic [XLEN-1:0] shifted;
    logic            byteSign;
    logic            halfSign;

    assign shifted  = data_i >> {offset_i, 3'b000};
    assign byteSign = ~unsign_i & shifted[7];
    assign halfSign = ~unsign_i & shifted[15];

    // An opcode with no size bit set falls back to a full-word load.
    always_comb begin
        result_o = shifted;
        if (opcode_i[MEM_OP_BYTE]) begin
            result_o = {{(XLEN-8){byteSign}}, shifted[7:0]};
        end else if (opcode_i[MEM_OP_HALF]) begin
            result_o = {{(XLEN-16){halfSign}}, shifted[15:0]};
        end else if (opcode_i[MEM_OP_WORD]) begin
            result_o = shifted;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: finishes loads (buffering early responses), passes ALU results through,
// drops read responses orphaned by a flush, and forwards rd / load-pending to ID.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,

    output logic                    mem_pipe_ready,
    output logic                    mem_pipe_flush,
    input  logic                    mem_pipe_valid,
    input  logic [XLEN-1:0]         mem_pipe_pc,
    input  logic [XLEN-1:0]         mem_pipe_instruction,
    input  logic [MEM_OP_WIDTH-1:0] mem_pipe_mem_opcode,
    input  logic                    mem_pipe_mem_read,
    input  logic                    mem_pipe_unsign,
    input  logic                    mem_pipe_rd_write,
    input  logic [REG_AW-1:0]       mem_pipe_rd_addr,
    input  logic [XLEN-1:0]         mem_pipe_alu_result,

    input  logic                    dram_data_ok,
    input  logic [XLEN-1:0]         dram_rdata,

    input  logic                    wb_pipe_ready,
    input  logic                    wb_pipe_flush,
    output logic                    wb_pipe_valid,
    output logic [XLEN-1:0]         wb_pipe_pc,
    output logic [XLEN-1:0]         wb_pipe_instruction,
    output logic                    wb_pipe_rd_write,
    output logic [REG_AW-1:0]       wb_pipe_rd_addr,
    output logic [XLEN-1:0]         wb_pipe_rd_wdata,

    output logic                    mem_rd_write,
    output logic [REG_AW-1:0]       mem_rd_addr,
    output logic [XLEN-1:0]         mem_rd_wdata,
    output logic                    mem_load_pending
);

    drain_state_e    state_q;
    logic [1:0]      drainCnt_q;
    logic [1:0]      drainCnt_d;
    logic            rbufValid_q;
    logic [XLEN-1:0] rbufData_q;

    logic            wbValid_q;
    logic [XLEN-1:0] wbPc_q;
    logic [XLEN-1:0] wbInstr_q;
    logic            wbRdWrite_q;
    logic [REG_AW-1:0] wbRdAddr_q;
    logic [XLEN-1:0] wbRdWdata_q;

    logic            memValid;
    logic            memDone;
    logic            liveDataOk;
    logic            orphan;
    logic            drop;
    logic            capture;
    logic [XLEN-1:0] loadSrc;
    logic [XLEN-1:0] loadData;
    logic [XLEN-1:0] finalResult;

    assign memValid   = mem_pipe_valid & ~wb_pipe_flush;
    assign liveDataOk = dram_data_ok & (state_q == RUN);
    assign memDone    = ~mem_pipe_mem_read | rbufValid_q | liveDataOk;

    assign mem_pipe_ready = ~memValid | (wb_pipe_ready & memDone);
    assign mem_pipe_flush = wb_pipe_flush;

    // A flushed load whose response is still outstanding leaves one orphan response on the bus.
    assign orphan  = wb_pipe_flush & mem_pipe_valid & mem_pipe_mem_read
                   & ~rbufValid_q & ~liveDataOk;
    assign drop    = dram_data_ok & (state_q == DRAIN);
    assign capture = liveDataOk & memValid & mem_pipe_mem_read
                   & ~wb_pipe_ready & ~rbufValid_q;

    assign loadSrc = rbufValid_q ? rbufData_q : dram_rdata;

    load_align uAlign (
        .data_i   (loadSrc),
        .offset_i (mem_pipe_alu_result[1:0]),
        .opcode_i (mem_pipe_mem_opcode),
        .unsign_i (mem_pipe_unsign),
        .result_o (loadData)
    );

    assign finalResult = mem_pipe_mem_read ? loadData : mem_pipe_alu_result;

    // Simultaneous orphan and drop cancel; the counter saturates at 3.
    always_comb begin
        drainCnt_d = drainCnt_q;
        if (orphan && !drop) begin
            if (drainCnt_q != 2'd3) begin
                drainCnt_d = drainCnt_q + 2'd1;
            end
        end else if (drop && !orphan) begin
            drainCnt_d = drainCnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            drainCnt_q <= 2'd0;
        end else begin
            drainCnt_q <= drainCnt_d;
            state_q    <= (drainCnt_d != 2'd0) ? DRAIN : RUN;
        end
    end

    // The buffer belongs to the load in MEM, so a flush discards it as well as a hand-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            rbufValid_q <= 1'b0;
        end else if (wb_pipe_ready || wb_pipe_flush) begin
            rbufValid_q <= 1'b0;
        end else if (capture) begin
            rbufValid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            rbufData_q <= dram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbValid_q <= 1'b0;
        end else if (wb_pipe_ready) begin
            wbValid_q <= memValid & memDone;
        end
    end

    always_ff @(posedge clk) begin
        if (wb_pipe_ready) begin
            wbPc_q      <= mem_pipe_pc;
            wbInstr_q   <= mem_pipe_instruction;
            wbRdWrite_q <= mem_pipe_rd_write;
            wbRdAddr_q  <= mem_pipe_rd_addr;
            wbRdWdata_q <= finalResult;
        end
    end

    assign wb_pipe_valid       = wbValid_q;
    assign wb_pipe_pc          = wbPc_q;
    assign wb_pipe_instruction = wbInstr_q;
    assign wb_pipe_rd_write    = wbRdWrite_q;
    assign wb_pipe_rd_addr     = wbRdAddr_q;
    assign wb_pipe_rd_wdata    = wbRdWdata_q;

    assign mem_rd_write     = mem_pipe_valid & mem_pipe_rd_write;
    assign mem_rd_addr      = mem_pipe_rd_addr;
    assign mem_rd_wdata     = finalResult;
    assign mem_load_pending = mem_pipe_valid & mem_pipe_mem_read & ~memDone;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions push expected WB beats, a monitor pops them.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_pipe_ready, mem_pipe_flush, mem_pipe_valid;
    logic [31:0] mem_pipe_pc, mem_pipe_instruction;
    logic [2:0]  mem_pipe_mem_opcode;
    logic        mem_pipe_mem_read, mem_pipe_unsign, mem_pipe_rd_write;
    logic [4:0]  mem_pipe_rd_addr;
    logic [31:0] mem_pipe_alu_result;
    logic        dram_data_ok;
    logic [31:0] dram_rdata;
    logic        wb_pipe_ready, wb_pipe_flush, wb_pipe_valid;
    logic [31:0] wb_pipe_pc, wb_pipe_instruction;
    logic        wb_pipe_rd_write;
    logic [4:0]  wb_pipe_rd_addr;
    logic [31:0] wb_pipe_rd_wdata;
    logic        mem_rd_write;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_rd_wdata;
    logic        mem_load_pending;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rdAddr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [2:0]  op;
        logic        uns;
        logic [1:0]  addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } loadVec_t;

    beat_t    sbQueue[$];
    loadVec_t loadVecs[6];
    int       checks = 0;
    int       errors = 0;
    logic [31:0] pcNext = 32'h0000_1000;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .mem_pipe_ready       (mem_pipe_ready),
        .mem_pipe_flush       (mem_pipe_flush),
        .mem_pipe_valid       (mem_pipe_valid),
        .mem_pipe_pc          (mem_pipe_pc),
        .mem_pipe_instruction (mem_pipe_instruction),
        .mem_pipe_mem_opcode  (mem_pipe_mem_opcode),
        .mem_pipe_mem_read    (mem_pipe_mem_read),
        .mem_pipe_unsign      (mem_pipe_unsign),
        .mem_pipe_rd_write    (mem_pipe_rd_write),
        .mem_pipe_rd_addr     (mem_pipe_rd_addr),
        .mem_pipe_alu_result  (mem_pipe_alu_result),
        .dram_data_ok         (dram_data_ok),
        .dram_rdata           (dram_rdata),
        .wb_pipe_ready        (wb_pipe_ready),
        .wb_pipe_flush        (wb_pipe_flush),
        .wb_pipe_valid        (wb_pipe_valid),
        .wb_pipe_pc           (wb_pipe_pc),
        .wb_pipe_instruction  (wb_pipe_instruction),
        .wb_pipe_rd_write     (wb_pipe_rd_write),
        .wb_pipe_rd_addr      (wb_pipe_rd_addr),
        .wb_pipe_rd_wdata     (wb_pipe_rd_wdata),
        .mem_rd_write         (mem_rd_write),
        .mem_rd_addr          (mem_rd_addr),
        .mem_rd_wdata         (mem_rd_wdata),
        .mem_load_pending     (mem_load_pending)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one EX payload; when push is set the matching WB beat is queued for the monitor.
    task automatic applyStimulus(input logic read, input logic [2:0] op, input logic uns,
                                 input logic [31:0] alu, input logic push, input logic [31:0] expWdata);
        beat_t b;
        mem_pipe_valid       = 1'b1;
        mem_pipe_pc          = pcNext;
        mem_pipe_instruction = pcNext ^ 32'h0000_0013;
        mem_pipe_mem_read    = read;
        mem_pipe_mem_opcode  = op;
        mem_pipe_unsign      = uns;
        mem_pipe_rd_write    = 1'b1;
        mem_pipe_rd_addr     = pcNext[6:2];
        mem_pipe_alu_result  = alu;
        if (push) begin
            b.pc     = pcNext;
            b.instr  = pcNext ^ 32'h0000_0013;
            b.rdAddr = pcNext[6:2];
            b.wdata  = expWdata;
            sbQueue.push_back(b);
        end
        pcNext = pcNext + 32'd4;
    endtask

    task automatic idleInputs();
        mem_pipe_valid = 1'b0;
        dram_data_ok   = 1'b0;
        dram_rdata     = 32'h0;
        wb_pipe_flush  = 1'b0;
    endtask

    // Load accepted with its response one cycle after entry.
    task automatic doLoad(input loadVec_t v);
        wb_pipe_ready = 1'b1;
        applyStimulus(1'b1, v.op, v.uns, {28'h0000_020, 2'b00, v.addr}, 1'b1, v.exp);
        @(negedge clk);
        checkOutput("loadPendingWait", {31'b0, mem_load_pending}, 32'd1);
        checkOutput("readyWait", {31'b0, mem_pipe_ready}, 32'd0);
        nextCycle();
        dram_data_ok = 1'b1;
        dram_rdata   = v.rdata;
        @(negedge clk);
        checkOutput("loadPendingDone", {31'b0, mem_load_pending}, 32'd0);
        checkOutput("fwdLoadData", mem_rd_wdata, v.exp);
        nextCycle();
        idleInputs();
        nextCycle();
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!rst && wb_pipe_valid && wb_pipe_ready) begin
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL wbUnexpectedBeat: got pc %h expected no beat", wb_pipe_pc);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("wbPc", wb_pipe_pc, e.pc);
                checkOutput("wbInstr", wb_pipe_instruction, e.instr);
                checkOutput("wbRdAddr", {27'b0, wb_pipe_rd_addr}, {27'b0, e.rdAddr});
                checkOutput("wbRdWdata", wb_pipe_rd_wdata, e.wdata);
            end
        end
    end

    initial begin
        loadVecs[0] = '{op: 3'b001, uns: 1'b0, addr: 2'd3, rdata: 32'h80FF_0000, exp: 32'hFFFF_FF80};
        loadVecs[1] = '{op: 3'b001, uns: 1'b1, addr: 2'd3, rdata: 32'h80FF_0000, exp: 32'h0000_0080};
        loadVecs[2] = '{op: 3'b001, uns: 1'b0, addr: 2'd1, rdata: 32'h0000_7F00, exp: 32'h0000_007F};
        loadVecs[3] = '{op: 3'b010, uns: 1'b1, addr: 2'd0, rdata: 32'h1234_F00D, exp: 32'h0000_F00D};
        loadVecs[4] = '{op: 3'b010, uns: 1'b0, addr: 2'd2, rdata: 32'h7FFF_0000, exp: 32'h0000_7FFF};
        loadVecs[5] = '{op: 3'b100, uns: 1'b0, addr: 2'd0, rdata: 32'hCAFE_BABE, exp: 32'hCAFE_BABE};

        rst = 1'b1;
        wb_pipe_ready = 1'b1;
        idleInputs();
        applyStimulus(1'b0, 3'b100, 1'b0, 32'h0, 1'b0, 32'h0);
        mem_pipe_valid = 1'b0;
        repeat (2) nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("resetWbValid", {31'b0, wb_pipe_valid}, 32'd0);
        checkOutput("resetReady", {31'b0, mem_pipe_ready}, 32'd1);
        checkOutput("resetPending", {31'b0, mem_load_pending}, 32'd0);
        nextCycle();

        // ALU passthrough
        applyStimulus(1'b0, 3'b100, 1'b0, 32'h0000_1234, 1'b1, 32'h0000_1234);
        @(negedge clk);
        checkOutput("aluReady", {31'b0, mem_pipe_ready}, 32'd1);
        checkOutput("aluFwdWrite", {31'b0, mem_rd_write}, 32'd1);
        nextCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("aluWbValid", {31'b0, wb_pipe_valid}, 32'd1);
        nextCycle();

        for (int i = 0; i < 6; i++) begin
            doLoad(loadVecs[i]);
        end

        // LH with WB stalled around the response: the buffer must hold the data
        wb_pipe_ready = 1'b0;
        applyStimulus(1'b1, 3'b010, 1'b0, 32'h0000_0102, 1'b1, 32'hFFFF_8001);
        nextCycle();
        dram_data_ok = 1'b1;
        dram_rdata   = 32'h8001_5555;
        @(negedge clk);
        checkOutput("stallReady", {31'b0, mem_pipe_ready}, 32'd0);
        nextCycle();
        dram_data_ok = 1'b0;
        dram_rdata   = 32'h0;
        @(negedge clk);
        checkOutput("stallBufferedData", mem_rd_wdata, 32'hFFFF_8001);
        checkOutput("stallPending", {31'b0, mem_load_pending}, 32'd0);
        nextCycle();
        wb_pipe_ready = 1'b1;
        @(negedge clk);
        checkOutput("stallRelease", {31'b0, mem_pipe_ready}, 32'd1);
        nextCycle();
        idleInputs();
        repeat (2) nextCycle();

        // Flush orphan: the first response belongs to the flushed load and is dropped
        applyStimulus(1'b1, 3'b100, 1'b0, 32'h0000_0200, 1'b0, 32'h0);
        nextCycle();
        wb_pipe_flush = 1'b1;
        @(negedge clk);
        checkOutput("flushForward", {31'b0, mem_pipe_flush}, 32'd1);
        checkOutput("flushReady", {31'b0, mem_pipe_ready}, 32'd1);
        nextCycle();
        wb_pipe_flush = 1'b0;
        applyStimulus(1'b1, 3'b100, 1'b0, 32'h0000_0300, 1'b1, 32'h0000_0042);
        dram_data_ok = 1'b1;
        dram_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("orphanDropped", {31'b0, mem_load_pending}, 32'd1);
        nextCycle();
        dram_rdata = 32'h0000_0042;
        @(negedge clk);
        checkOutput("orphanNextLoad", mem_rd_wdata, 32'h0000_0042);
        checkOutput("orphanNextReady", {31'b0, mem_pipe_ready}, 32'd1);
        nextCycle();
        idleInputs();
        repeat (2) nextCycle();

        // Backpressure burst of four ALU ops against a WB ready pattern
        begin
            logic [7:0] wbPattern = 8'b1001_0110;
            logic       accepted;
            logic       issued = 1'b0;
            int         n = 0;
            int         k = 0;
            while (n < 4 && k < 40) begin
                if (!issued) begin
                    applyStimulus(1'b0, 3'b100, 1'b0, 32'hA000_0000 + n, 1'b1, 32'hA000_0000 + n);
                    issued = 1'b1;
                end
                wb_pipe_ready = wbPattern[k % 8];
                @(negedge clk);
                if (!wb_pipe_ready) checkOutput("bpReadyLow", {31'b0, mem_pipe_ready}, 32'd0);
                accepted = mem_pipe_ready;
                nextCycle();
                k++;
                if (accepted) begin
                    n++;
                    issued = 1'b0;
                end
            end
            if (n < 4) begin
                checks++;
                errors++;
                $display("[TB] FAIL bpTimeout: got %0d accepted expected 4", n);
            end
        end
        idleInputs();
        wb_pipe_ready = 1'b1;
        repeat (3) nextCycle();

        // Reset while draining: a following load must complete with its own response
        applyStimulus(1'b1, 3'b100, 1'b0, 32'h0000_0400, 1'b0, 32'h0);
        nextCycle();
        wb_pipe_flush = 1'b1;
        nextCycle();
        wb_pipe_flush = 1'b0;
        applyStimulus(1'b0, 3'b100, 1'b0, 32'h0000_5555, 1'b0, 32'h0);
        nextCycle();
        mem_pipe_valid = 1'b0;
        wb_pipe_ready  = 1'b0;
        rst            = 1'b1;
        @(negedge clk);
        checkOutput("preResetWbValid", {31'b0, wb_pipe_valid}, 32'd1);
        nextCycle();
        rst           = 1'b0;
        wb_pipe_ready = 1'b1;
        applyStimulus(1'b1, 3'b100, 1'b0, 32'h0000_0500, 1'b1, 32'h0000_0077);
        @(negedge clk);
        checkOutput("postResetWbValid", {31'b0, wb_pipe_valid}, 32'd0);
        nextCycle();
        dram_data_ok = 1'b1;
        dram_rdata   = 32'h0000_0077;
        @(negedge clk);
        checkOutput("postResetPending", {31'b0, mem_load_pending}, 32'd0);
        checkOutput("postResetData", mem_rd_wdata, 32'h0000_0077);
        nextCycle();
        idleInputs();

        for (int w = 0; w < 20 && sbQueue.size() != 0; w++) nextCycle();
        nextCycle();
        checkOutput("scoreboardEmpty", sbQueue.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
